// File: rtl/proj001_pkg.sv
// Shared definitions for the computation unit, the result buffer and their benches.
package proj001_pkg;

   localparam int RESULT_W = 5;
   localparam int DATA_W   = 4;
   localparam int RB_DEPTH = 8;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_OR  = 2'd3;

   // Saturating increment for 16-bit event counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = 16'hFFFF;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rb_mem.sv
// Result buffer storage: DEPTH x WIDTH register array, one synchronous write
// port and one asynchronous read port. Contents are never reset.
module rb_mem #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Write port: store the incoming word at the write address.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/result_buffer.sv
// First-word-fall-through result FIFO with occupancy and sticky overflow.
// Optional RESULT_BUFFER_STATS_EN adds total_cnt and max_result outputs.
module result_buffer
   import proj001_pkg::*;
#(
   parameter int WIDTH = RESULT_W,
   parameter int DEPTH = RB_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   input  logic             ovf_clr
`ifdef RESULT_BUFFER_STATS_EN
   ,
   output logic [15:0]      total_cnt,
   output logic [WIDTH-1:0] max_result
`endif
);

   localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             ovf_r;
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   logic             drop_s;
   logic             mem_we_s;
   logic [WIDTH-1:0] rdata_s;

   assign full_s  = (count_r == COUNT_FULL);
   assign empty_s = (count_r == {(AW+1){1'b0}});

   // Handshake decode; a pop frees the slot a push at full reuses.
   always_comb begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      drop_s = 1'b0;
      if (!empty_s && out_ready) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      if (in_valid && (!full_s || pop_s)) begin
         push_s = 1'b1;
      end else if (in_valid) begin
         drop_s = 1'b1;
      end else begin
         push_s = 1'b0;
         drop_s = 1'b0;
      end
   end

   // Nothing reaches the array during reset.
   assign mem_we_s = push_s && !rst;

   rb_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock (clock),
      .we    (mem_we_s),
      .waddr (wr_ptr_r),
      .wdata (in_data),
      .raddr (rd_ptr_r),
      .rdata (rdata_s)
   );

   // Pointer, occupancy and sticky overflow state.
   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
         ovf_r    <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (push_s && !pop_s) begin
            count_r <= count_r + COUNT_ONE;
         end else if (pop_s && !push_s) begin
            count_r <= count_r - COUNT_ONE;
         end
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Unwritten storage is masked so an empty buffer always reads zero.
   assign out_valid = !empty_s;
   assign out_data  = empty_s ? {WIDTH{1'b0}} : rdata_s;
   assign count     = count_r;
   assign full      = full_s;
   assign empty     = empty_s;
   assign overflow  = ovf_r;

`ifdef RESULT_BUFFER_STATS_EN
   logic [15:0]      total_cnt_r;
   logic [WIDTH-1:0] max_result_r;

   // Accepted-push statistics; dropped words are not counted.
   always_ff @(posedge clock) begin
      if (rst) begin
         total_cnt_r  <= 16'd0;
         max_result_r <= {WIDTH{1'b0}};
      end else if (push_s) begin
         total_cnt_r <= sat_inc16(total_cnt_r);
         if (in_data > max_result_r) begin
            max_result_r <= in_data;
         end
      end
   end

   assign total_cnt  = total_cnt_r;
   assign max_result = max_result_r;
`endif

endmodule
